// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory command port and its arbiter.
//   mem_cmd_t    : command presented to data memory (address, write data, read/write strobes,
//                  byte mask).
//   mem_result_t : memory result; read_data is combinational from the command.
//   requester_e  : identifies which requester owns a grant or a read return.
package dmem_arbiter_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] write_data;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mask_byte;
    } mem_cmd_t;

    typedef struct packed {
        logic [31:0] read_data;
    } mem_result_t;

    typedef enum logic {
        REQ_CORE,
        REQ_LOADER
    } requester_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating 8-bit wait counter used to bound loader starvation.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   inc  : count one more waiting cycle (stops at MAX)
//   clr  : clear to zero, wins over inc
//   sat  : counter has reached MAX
module starve_counter #(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [7:0] MaxCnt = 8'(MAX);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign sat = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single data-memory command port.
// Shares the port between the core load/store unit (c_*) and the loader/debug port (l_*).
//   clk, rst             : clock, asynchronous active-low reset
//   c_req/c_lock/c_cmd   : core request, ownership hold for following cycles, command
//   c_gnt                : core command is on mem_cmd this cycle
//   c_rvalid/c_rdata     : registered read return for the core grant of the previous cycle
//   l_req/l_cmd          : loader request and command (no lock)
//   l_gnt/l_rvalid/l_rdata : loader grant and read return
//   mem_cmd / mem_res    : command to data memory, combinational read result
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_lock,
    input  mem_cmd_t    c_cmd,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  mem_cmd_t    l_cmd,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output mem_cmd_t    mem_cmd,
    input  mem_result_t mem_res
);

    typedef enum logic {
        OPEN,
        LOCKED
    } state_e;

    state_e      state_q;
    logic        starved;
    logic        any_gnt;
    requester_e  winner;
    logic        cnt_inc;
    logic        cnt_clr;
    logic        c_rvalid_q, l_rvalid_q;
    logic [31:0] c_rdata_q, l_rdata_q;

    // Grants are gated by rst so that an asserted reset silences the port immediately,
    // including a write that would otherwise commit at the next edge.
    always_comb begin
        any_gnt = 1'b0;
        winner  = REQ_CORE;
        if (rst) begin
            if (state_q == LOCKED) begin
                any_gnt = c_req;
                winner  = REQ_CORE;
            end else if (starved && l_req) begin
                any_gnt = 1'b1;
                winner  = REQ_LOADER;
            end else if (c_req) begin
                any_gnt = 1'b1;
                winner  = REQ_CORE;
            end else if (l_req) begin
                any_gnt = 1'b1;
                winner  = REQ_LOADER;
            end
        end
    end

    assign c_gnt = any_gnt && (winner == REQ_CORE);
    assign l_gnt = any_gnt && (winner == REQ_LOADER);

    always_comb begin
        mem_cmd = '0;
        if (c_gnt) begin
            mem_cmd = c_cmd;
        end else if (l_gnt) begin
            mem_cmd = l_cmd;
        end
    end

    assign cnt_inc = l_req && !l_gnt;
    assign cnt_clr = l_gnt || !l_req;

    starve_counter #(
        .MAX(MAX_WAIT)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(cnt_inc),
        .clr(cnt_clr),
        .sat(starved)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OPEN;
        end else begin
            case (state_q)
                OPEN:    if (c_gnt && c_lock) state_q <= LOCKED;
                LOCKED:  if (!c_req || !c_lock) state_q <= OPEN;
                default: state_q <= OPEN;
            endcase
        end
    end

    // Read returns: rdata only moves on a read to that requester, so it holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt && c_cmd.mem_read;
            l_rvalid_q <= l_gnt && l_cmd.mem_read;
            if (c_gnt && c_cmd.mem_read) c_rdata_q <= mem_res.read_data;
            if (l_gnt && l_cmd.mem_read) l_rdata_q <= mem_res.read_data;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;

endmodule
